// File: rtl/piton_sd_cache_lock_pkg.sv
// Shared types and helpers for the SD cache lock manager and its per-lock entries.
package piton_sd_cache_lock_pkg;

  // Storage widths for one lock entry. OWNER_W must not exceed OWNER_MAX_W.
  localparam int OWNER_MAX_W = 32;
  localparam int HOLD_MAX_W  = 32;

  typedef enum logic {
    ACQUIRE = 1'b0,
    RELEASE = 1'b1
  } lock_op_e;

  typedef enum logic {
    FREE = 1'b0,
    HELD = 1'b1
  } lock_state_e;

  typedef struct packed {
    lock_state_e            state;
    logic [OWNER_MAX_W-1:0] owner;
    logic [HOLD_MAX_W-1:0]  hold_cnt;
  } lock_entry_t;

  localparam lock_entry_t FREE_ENTRY = '{state: FREE, owner: '0, hold_cnt: '0};

  // Lock index width, at least one bit even for a single lock.
  function automatic int lock_idx_w(input int num_locks);
    return (num_locks <= 2) ? 1 : $clog2(num_locks);
  endfunction

endpackage

// File: rtl/piton_sd_cache_lock_entry.sv
// One lock: FREE/HELD(owner) FSM plus the hold counter built when
// PITON_SD_CACHE_LOCK_TIMEOUT_EN is defined.
module piton_sd_cache_lock_entry
  import piton_sd_cache_lock_pkg::*;
#(
  parameter int OWNER_W        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  lock_op_e           op,
  input  logic [OWNER_W-1:0] req_owner,
  output logic               held,
  output logic [OWNER_W-1:0] owner,
  output logic               ok,
  output logic               lock_evt,
  output logic               unlock_evt,
  output logic               timeout_pulse
);

  lock_entry_t q;
  lock_entry_t q_next;
  logic        expire;
  logic        eff_held;
  logic        same_owner;

`ifdef PITON_SD_CACHE_LOCK_TIMEOUT_EN
  assign expire = (q.state == HELD) &&
                  (q.hold_cnt == HOLD_MAX_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // A lock expiring on this edge is already FREE as far as the request is concerned.
  assign eff_held   = (q.state == HELD) && !expire;
  assign same_owner = (q.owner == OWNER_MAX_W'(req_owner));

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block infers a latch.
    ok         = 1'b0;
    lock_evt   = 1'b0;
    unlock_evt = 1'b0;
    q_next     = q;

`ifdef PITON_SD_CACHE_LOCK_TIMEOUT_EN
    if (expire) begin
      q_next = FREE_ENTRY;
    end else if (q.state == HELD) begin
      q_next.hold_cnt = q.hold_cnt + HOLD_MAX_W'(1);
    end
`endif

    if (op == ACQUIRE) begin
      ok       = !eff_held || same_owner;
      lock_evt = !eff_held;
    end else begin
      ok         = eff_held && same_owner;
      unlock_evt = ok;
    end

    if (sel && lock_evt) begin
      q_next = '{state: HELD, owner: OWNER_MAX_W'(req_owner), hold_cnt: '0};
    end else if (sel && unlock_evt) begin
      q_next = FREE_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q <= FREE_ENTRY;
    end else begin
      q <= q_next;
    end
  end

`ifdef PITON_SD_CACHE_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= expire;
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

  assign held  = (q.state == HELD);
  assign owner = q.owner[OWNER_W-1:0];

endmodule

// File: rtl/piton_sd_cache_lock_mgr.sv
// Multi-lock SD cache lock manager: request decode, one-entry response register and pulses.
// Optional forced release on hold timeout when PITON_SD_CACHE_LOCK_TIMEOUT_EN is defined.
module piton_sd_cache_lock_mgr
  import piton_sd_cache_lock_pkg::*;
#(
  parameter  int NUM_LOCKS      = 4,
  parameter  int OWNER_W        = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = lock_idx_w(NUM_LOCKS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_op,
  input  logic [IDX_W-1:0]             req_idx,
  input  logic [OWNER_W-1:0]           req_owner,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_ok,
  output logic [IDX_W-1:0]             rsp_idx,
  output logic [NUM_LOCKS-1:0]         lock_held,
  output logic [NUM_LOCKS*OWNER_W-1:0] lock_owner,
  output logic                         lock_pulse,
  output logic                         unlock_pulse,
  output logic [NUM_LOCKS-1:0]         timeout_pulse
);

  localparam int              IDX_W1      = IDX_W + 1;
  localparam logic [IDX_W:0]  NUM_LOCKS_L = IDX_W1'(NUM_LOCKS);

  logic                 accept;
  logic                 idx_ok;
  logic [NUM_LOCKS-1:0] sel;
  logic [NUM_LOCKS-1:0] ok_vec;
  logic [NUM_LOCKS-1:0] lock_vec;
  logic [NUM_LOCKS-1:0] unlock_vec;

  // Single response slot: a new request may enter whenever the slot drains this cycle.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign idx_ok    = {1'b0, req_idx} < NUM_LOCKS_L;

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_lock
    assign sel[i] = accept && idx_ok && (req_idx == IDX_W'(i));

    piton_sd_cache_lock_entry #(
      .OWNER_W        (OWNER_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .sel           (sel[i]),
      .op            (lock_op_e'(req_op)),
      .req_owner     (req_owner),
      .held          (lock_held[i]),
      .owner         (lock_owner[i*OWNER_W +: OWNER_W]),
      .ok            (ok_vec[i]),
      .lock_evt      (lock_vec[i]),
      .unlock_evt    (unlock_vec[i]),
      .timeout_pulse (timeout_pulse[i])
    );
  end

  // At most one sel bit is set, so OR-reducing the masked vectors selects that lock's decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_ok       <= 1'b0;
      rsp_idx      <= '0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
    end else begin
      lock_pulse   <= |(sel & lock_vec);
      unlock_pulse <= |(sel & unlock_vec);
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_ok    <= |(sel & ok_vec);
        rsp_idx   <= req_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
